fifo_stream_drain: RTL and testbench

- Read-side consumer placed directly downstream of the synchronous FIFO.
- Pops words from the FIFO's rd_en/data_out port, which has 1-cycle read latency.
- Re-presents the words as a valid/ready stream, with a 2-entry skid buffer so downstream stalls never drop an in-flight read.
- Frames the stream into fixed-length packets (m_last) and keeps a running delivered-word count.

---
 rtl/fifo_stream_drain_pkg.sv | 34 +++
 rtl/fifo_stream_drain_skid.sv | 93 +++++++++
 rtl/fifo_stream_drain.sv | 104 ++++++++++
 tb/tb_fifo_stream_drain.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_drain_pkg.sv
// ----------------------------------------------------------------------------
// fifo_stream_drain_pkg
// Shared definitions for the FIFO read-side stream drain:
//   - occ_e      : occupancy of the 2-entry skid buffer
//   - DEF_*      : default parameter values for the drain and its buffer
//   - occ_count  : numeric occupancy (0..2) of an occ_e value
//   - idx_width  : width of the packet index counter for a given packet length
// ----------------------------------------------------------------------------
package fifo_stream_drain_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_PKT_LEN    = 4;
    localparam int DEF_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    function automatic logic [1:0] occ_count(input occ_e occ);
        case (occ)
            OCC_ONE: return 2'd1;
            OCC_TWO: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    // A one-word packet still needs a 1-bit index register.
    function automatic int idx_width(input int pkt_len);
        return (pkt_len > 1) ? $clog2(pkt_len) : 1;
    endfunction

endpackage

// File: rtl/fifo_stream_drain_skid.sv
// ----------------------------------------------------------------------------
// drain_skid_buf
// Two-entry skid buffer between the FIFO read port and the output stream.
// Words are written at the tail on push and leave from the head on pop; the
// head register drives the output data directly, so there is no
// combinational path from push_data to head.
//
// Ports:
//   clk        in   clock, all state on posedge
//   rst_n      in   asynchronous active-low reset
//   push       in   write push_data into the tail this cycle
//   push_data  in   [DATA_WIDTH] word to write
//   pop        in   head word consumed this cycle (only meaningful when valid)
//   flush      in   synchronous drop of all buffered words and of this push
//   valid      out  buffer holds at least one word
//   head       out  [DATA_WIDTH] oldest buffered word
//   occ        out  occupancy state
//
// state     | meaning
// ----------+--------------------------------------------------
// OCC_EMPTY | no words held, valid low
// OCC_ONE   | one word held in head
// OCC_TWO   | head plus one word parked in spare
// ----------------------------------------------------------------------------
module drain_skid_buf
    import fifo_stream_drain_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] head,
    output occ_e                  occ
);

    logic [DATA_WIDTH-1:0] spare;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ   <= OCC_EMPTY;
            head  <= '0;
            spare <= '0;
        end else if (flush) begin
            // A word arriving in the flush cycle belongs to the dropped
            // stream and is not captured.
            occ <= OCC_EMPTY;
        end else begin
            case (occ)
                OCC_EMPTY: begin
                    if (push) begin
                        head <= push_data;
                        occ  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            spare <= push_data;
                            occ   <= OCC_TWO;
                        end
                        2'b01: begin
                            occ <= OCC_EMPTY;
                        end
                        2'b11: begin
                            head <= push_data;
                        end
                        default: ;
                    endcase
                end
                OCC_TWO: begin
                    // The issue rule upstream never lets a push land here.
                    if (pop) begin
                        head <= spare;
                        occ  <= OCC_ONE;
                    end
                end
                default: occ <= OCC_EMPTY;
            endcase
        end
    end

    assign valid = (occ != OCC_EMPTY);

    a_no_push_when_full : assert property (
        @(posedge clk) disable iff (!rst_n) !(push && (occ == OCC_TWO))
    );

endmodule

// File: rtl/fifo_stream_drain.sv
// ----------------------------------------------------------------------------
// fifo_stream_drain
// Read-side consumer for a synchronous FIFO with 1-cycle read latency.
// Issues FIFO reads only when a returning word is guaranteed a slot in the
// 2-entry skid buffer, presents the words as a valid/ready stream, marks
// every PKT_LEN-th delivered word with m_last and counts delivered words.
//
// Ports:
//   clk         in   clock, all state on posedge
//   rst_n       in   asynchronous active-low reset
//   fifo_dout   in   [DATA_WIDTH] FIFO read data, valid the cycle after a read
//   fifo_empty  in   FIFO empty flag
//   fifo_rd_en  out  FIFO read request (combinational)
//   flush       in   synchronous drop of buffered and in-flight words
//   m_valid     out  output word valid
//   m_ready     in   downstream accept
//   m_data      out  [DATA_WIDTH] output word
//   m_last      out  last word of a packet, qualified by m_valid
//   beat_cnt    out  [CNT_WIDTH] words delivered, wraps
// ----------------------------------------------------------------------------
module fifo_stream_drain
    import fifo_stream_drain_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PKT_LEN    = DEF_PKT_LEN,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  beat_cnt
);

    localparam int             IDX_W    = idx_width(PKT_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_LEN - 1);

    logic             rd_pending;
    logic             pop;
    occ_e             occ;
    logic [2:0]       load;
    logic [IDX_W-1:0] pkt_idx;

    drain_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pending),
        .push_data (fifo_dout),
        .pop       (pop),
        .flush     (flush),
        .valid     (m_valid),
        .head      (m_data),
        .occ       (occ)
    );

    assign pop = m_valid & m_ready;

    // Slots committed after this edge: held words plus the word already in
    // flight, minus the word leaving now. A new read is safe only if at most
    // one slot is committed, leaving room for the word it will return.
    assign load = {1'b0, occ_count(occ)} + {2'b00, rd_pending} - {2'b00, pop};

    // Gated by rst_n so the read request drops with the rest of the outputs
    // as soon as reset asserts.
    assign fifo_rd_en = rst_n & ~fifo_empty & ~flush & (load <= 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= fifo_rd_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_idx <= '0;
        end else if (flush) begin
            pkt_idx <= '0;
        end else if (pop) begin
            pkt_idx <= (pkt_idx == IDX_LAST) ? '0 : pkt_idx + IDX_W'(1);
        end
    end

    // A word accepted in the flush cycle was delivered, so it still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= beat_cnt + CNT_WIDTH'(1);
        end
    end

    assign m_last = m_valid & (pkt_idx == IDX_LAST);

endmodule

// File: tb/tb_fifo_stream_drain.sv
module tb_fifo_stream_drain;
    import fifo_stream_drain_pkg::*;

    localparam int DW = 16;
    localparam int PL = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic          flush = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [CW-1:0] beat_cnt;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            failures = 0;

    logic [DW-1:0] fifo_mem [0:255];
    int            wr_ptr = 0;
    int            rd_ptr = 0;

    fifo_stream_drain #(
        .DATA_WIDTH (DW),
        .PKT_LEN    (PL),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .beat_cnt   (beat_cnt)
    );

    always #5 clk = ~clk;

    // Upstream synchronous FIFO: 1-cycle read latency, emptied while reset is held.
    assign fifo_empty = (rd_ptr == wr_ptr);
    always @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en) begin
            fifo_dout <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endfunction

    task automatic load_word(input logic [DW-1:0] d, input logic last, input logic expect_it);
        fifo_mem[wr_ptr] = d;
        wr_ptr++;
        if (expect_it) exp_q.push_back('{data: d, last: last});
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor / scoreboard
    logic [CW-1:0] exp_beats = '0;
    logic          prev_stall = 1'b0;
    logic          prev_flush = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_beats  = '0;
            prev_stall = 1'b0;
            prev_flush = 1'b0;
            exp_q.delete();
        end else begin
            if (prev_stall && !prev_flush) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", 32'(m_data), 32'(prev_data));
            end
            if (!m_valid) chk("idle_last", 32'(m_last), 32'd0);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_word: actual=0x%0h expected=none", m_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("word_data", 32'(m_data), 32'(e.data));
                    chk("word_last", 32'(m_last), 32'(e.last));
                    chk("word_beat", 32'(beat_cnt), 32'(exp_beats));
                end
                exp_beats = exp_beats + 4'd1;
            end
            prev_stall = m_valid & ~m_ready;
            prev_flush = flush;
            prev_data  = m_data;
        end
    end

    initial begin
        int rd_cnt;
        int n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_last", 32'(m_last), 32'd0);
        chk("rst_beat", 32'(beat_cnt), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1: latency and back-to-back delivery
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) load_word(DW'(16'hA001 + i), (i == 3), 1'b1);
        #1;
        chk("t1_rd_en", 32'(fifo_rd_en), 32'd1);
        @(posedge clk); #1;
        chk("t1_valid_n1", 32'(m_valid), 32'd0);
        @(posedge clk); #1;
        chk("t1_valid_n2", 32'(m_valid), 32'd1);
        chk("t1_data_n2", 32'(m_data), 32'h0000A001);
        repeat (4) @(posedge clk);
        #1;
        chk("t1_beat", 32'(beat_cnt), 32'd4);
        chk("t1_drained", 32'(exp_q.size()), 32'd0);
        chk("t1_valid_end", 32'(m_valid), 32'd0);

        // T2: 10-cycle stall with a full FIFO
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) load_word(DW'(16'hD001 + i), ((i % 4) == 3), 1'b1);
        #1;
        rd_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (fifo_rd_en) rd_cnt++;
            @(posedge clk);
            #1;
        end
        chk("t2_rd_cnt", 32'(rd_cnt), 32'd2);
        chk("t2_occ", 32'(dut.u_buf.occ), 32'(OCC_TWO));
        chk("t2_data", 32'(m_data), 32'h0000D001);
        m_ready = 1'b1;
        wait_drain("t2_drain", 40);
        chk("t2_beat", 32'(beat_cnt), 32'd12);

        // T3: ready toggling every cycle over 12 words
        for (int i = 0; i < 12; i++) load_word(DW'(16'hE001 + i), ((i % 4) == 3), 1'b1);
        n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            @(posedge clk);
            #1;
            m_ready = ~m_ready;
            n++;
        end
        chk("t3_drain", 32'(exp_q.size()), 32'd0);
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t3_beat", 32'(beat_cnt), 32'd8);

        // T4: flush with a word in flight; C003 is dropped
        for (int i = 0; i < 7; i++) load_word(DW'(16'hC001 + i), (i == 6), (i != 2));
        repeat (3) @(posedge clk);
        #1;
        chk("t4_occ_two", 32'(dut.u_buf.occ), 32'(OCC_TWO));
        chk("t4_pend0", 32'(dut.rd_pending), 32'd0);
        chk("t4_beat0", 32'(beat_cnt), 32'd8);
        m_ready = 1'b1;
        @(posedge clk); #1;
        chk("t4_pend1", 32'(dut.rd_pending), 32'd1);
        flush = 1'b1;
        #1;
        chk("t4_rd_en_flush", 32'(fifo_rd_en), 32'd0);
        chk("t4_beat1", 32'(beat_cnt), 32'd9);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("t4_valid_after", 32'(m_valid), 32'd0);
        chk("t4_beat2", 32'(beat_cnt), 32'd10);
        wait_drain("t4_drain", 30);
        @(posedge clk); #1;
        chk("t4_beat3", 32'(beat_cnt), 32'd14);

        // T5: asynchronous reset mid-stream
        for (int i = 0; i < 6; i++) load_word(DW'(16'hF001 + i), 1'b0, (i < 2));
        repeat (4) @(posedge clk);
        #2;
        chk("t5_valid_pre", 32'(m_valid), 32'd1);
        chk("t5_data_pre", 32'(m_data), 32'h0000F003);
        chk("t5_fifo_busy", 32'(fifo_empty), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t5_valid", 32'(m_valid), 32'd0);
        chk("t5_data", 32'(m_data), 32'd0);
        chk("t5_last", 32'(m_last), 32'd0);
        chk("t5_beat", 32'(beat_cnt), 32'd0);
        chk("t5_rd_en", 32'(fifo_rd_en), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("t5_rd_en_empty", 32'(fifo_rd_en), 32'd0);
        @(posedge clk); #1;
        chk("t5_valid_post", 32'(m_valid), 32'd0);

        // T6: 17 words, 4-bit beat counter wraps 15 -> 0 -> 1
        for (int i = 0; i < 17; i++) load_word(DW'(16'h9000 + i), ((i % 4) == 3), 1'b1);
        #1;
        chk("t6_rd_en", 32'(fifo_rd_en), 32'd1);
        wait_drain("t6_drain", 60);
        @(posedge clk); #1;
        chk("t6_beat", 32'(beat_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
